// File: rtl/xpb_lut_gen_if.sv
// xpb_lut_gen_if: bundles the control, operand and lookup signals of the
// self-generating xpb lookup table.
//   start/base/modulus            : (re)generation request with its operands
//   busy/ready/error              : table status
//   lookup_valid_in/data_in       : lookup request and index
//   data_out/data_valid_out       : lookup response
// The master modport is the requester; the slave modport is the table block.
interface xpb_lut_gen_if #(
  parameter int DATA_W = 1024,
  parameter int IDX_W  = 5
);
  logic              start;
  logic [DATA_W-1:0] base;
  logic [DATA_W-1:0] modulus;
  logic              busy;
  logic              ready;
  logic              error;
  logic              lookup_valid_in;
  logic [IDX_W-1:0]  data_in;
  logic [DATA_W-1:0] data_out;
  logic              data_valid_out;

  modport master (
    output start, base, modulus, lookup_valid_in, data_in,
    input  busy, ready, error, data_out, data_valid_out
  );

  modport slave (
    input  start, base, modulus, lookup_valid_in, data_in,
    output busy, ready, error, data_out, data_valid_out
  );
endinterface

// File: rtl/xpb_lut_gen.sv
// xpb_lut_gen: builds the table entry[i] = (i * base) mod modulus for
// i = 0..2^IDX_W-1 with one modular add per cycle, then serves pipelined
// lookups from it.
//   clk   : rising-edge clock
//   reset : synchronous, active-high reset
//   bus   : xpb_lut_gen_if slave (start/base/modulus, busy/ready/error,
//           lookup_valid_in/data_in, data_out/data_valid_out)
// Parameters: DATA_W operand/entry width, IDX_W index width,
// OUT_REG lookup latency (1 or 2 cycles).
module xpb_lut_gen #(
  parameter int DATA_W  = 1024,
  parameter int IDX_W   = 5,
  parameter int OUT_REG = 1
) (
  input  logic           clk,
  input  logic           reset,
  xpb_lut_gen_if.slave   bus
);

  localparam int DEPTH = 32'd1 << IDX_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GEN   = 2'd1,
    READY = 2'd2,
    ERR   = 2'd3
  } state_t;

  state_t            state_r;
  state_t            state_s;
  logic              busy_r;
  logic              ready_r;
  logic              error_r;

  logic [DATA_W-1:0] b_r;
  logic [DATA_W-1:0] m_r;
  logic [DATA_W-1:0] acc_r;
  logic [DATA_W-1:0] acc_next_s;
  logic [DATA_W:0]   sum_s;
  logic [IDX_W-1:0]  k_r;
  logic              k_last_s;
  logic              start_ok_s;
  logic              illegal_s;

  logic [DATA_W-1:0] table_r [DEPTH];

  logic [DATA_W-1:0] d1_r;
  logic              v1_r;

  // Start qualification, operand legality and the modular accumulate step.
  always_comb begin
    start_ok_s = bus.start && (state_r != GEN);
    illegal_s  = (bus.modulus == {DATA_W{1'b0}}) || (bus.base >= bus.modulus);
    k_last_s   = (k_r == {IDX_W{1'b1}});
    sum_s      = {1'b0, acc_r} + {1'b0, b_r};
    // acc < M and B < M, so sum < 2M: one conditional subtraction suffices.
    // The difference is < M and fits in DATA_W bits, so the low bits are exact.
    if (sum_s >= {1'b0, m_r}) begin
      acc_next_s = sum_s[DATA_W-1:0] - m_r;
    end else begin
      acc_next_s = sum_s[DATA_W-1:0];
    end
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE, READY, ERR: begin
        if (bus.start) begin
          state_s = illegal_s ? ERR : GEN;
        end else begin
          state_s = state_r;
        end
      end
      GEN: begin
        if (k_last_s) begin
          state_s = READY;
        end else begin
          state_s = GEN;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // State register; status flags are registered from the next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
      busy_r  <= 1'b0;
      ready_r <= 1'b0;
      error_r <= 1'b0;
    end else begin
      state_r <= state_s;
      busy_r  <= (state_s == GEN);
      ready_r <= (state_s == READY);
      error_r <= (state_s == ERR);
    end
  end

  // Operand latch, accumulator and entry counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      b_r   <= {DATA_W{1'b0}};
      m_r   <= {DATA_W{1'b0}};
      acc_r <= {DATA_W{1'b0}};
      k_r   <= {IDX_W{1'b0}};
    end else if (start_ok_s) begin
      b_r   <= bus.base;
      m_r   <= bus.modulus;
      acc_r <= {DATA_W{1'b0}};
      k_r   <= {IDX_W{1'b0}};
    end else if (state_r == GEN) begin
      acc_r <= acc_next_s;
      k_r   <= k_r + {{(IDX_W-1){1'b0}}, 1'b1};
    end
  end

  // Table storage; contents are only exposed in READY, so no reset is needed.
  always_ff @(posedge clk) begin
    if (state_r == GEN) begin
      table_r[k_r] <= acc_r;
    end
  end

  // First lookup stage: serve in READY, flush to zero elsewhere.
  always_ff @(posedge clk) begin
    if (reset) begin
      v1_r <= 1'b0;
      d1_r <= {DATA_W{1'b0}};
    end else if (state_r == READY) begin
      v1_r <= bus.lookup_valid_in;
      if (bus.lookup_valid_in) begin
        d1_r <= table_r[bus.data_in];
      end
    end else begin
      v1_r <= 1'b0;
      d1_r <= {DATA_W{1'b0}};
    end
  end

  generate
    if (OUT_REG == 2) begin : g_out2
      logic [DATA_W-1:0] d2_r;
      logic              v2_r;

      // Optional second output stage.
      always_ff @(posedge clk) begin
        if (reset) begin
          v2_r <= 1'b0;
          d2_r <= {DATA_W{1'b0}};
        end else begin
          v2_r <= v1_r;
          d2_r <= d1_r;
        end
      end

      assign bus.data_out       = d2_r;
      assign bus.data_valid_out = v2_r;
    end else begin : g_out1
      assign bus.data_out       = d1_r;
      assign bus.data_valid_out = v1_r;
    end
  endgenerate

  assign bus.busy  = busy_r;
  assign bus.ready = ready_r;
  assign bus.error = error_r;

endmodule
